sif_posted: RTL

Parametrised second-generation serial-interface register bridge. Host accesses on the xa bus update a local shadow register file and are forwarded to the wa bus through a posted-write FIFO. A wa-side acknowledge handshake with timeout drives the forwarding, and host reads return shadow data or a status word. The block sits between the host-side xa bus and the downstream wa register target, replacing the fixed-width, unbuffered bridge.

---
 rtl/sif_posted_if.sv | 27 ++
 rtl/sif_posted.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sif_posted_if.sv
// Host-side xa bus and downstream wa bus of the posted-write register bridge.
interface sif_posted_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              xa_wr_s;
    logic              xa_rd_s;
    logic [ADDR_W-1:0] xa_addr;
    logic [DATA_W-1:0] xa_data_wr;
    logic [DATA_W-1:0] xa_data_rd;
    logic              xa_rd_vld;
    logic              xa_full;
    logic              wa_wr_s;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data_wr;
    logic              wa_ack;

    modport slave (
        input  xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, wa_ack,
        output xa_data_rd, xa_rd_vld, xa_full, wa_wr_s, wa_addr, wa_data_wr
    );

    modport master (
        output xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, wa_ack,
        input  xa_data_rd, xa_rd_vld, xa_full, wa_wr_s, wa_addr, wa_data_wr
    );
endinterface

// File: rtl/sif_posted.sv
// Register bridge: host writes update a shadow file and are posted through a FIFO
// to the wa target, which must acknowledge each write within ACK_TO cycles.
module sif_posted #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ACK_TO     = 8
) (
    input  logic         clk,
    input  logic         rst,
    sif_posted_if.slave  bus
);
    localparam int STAT_ADDR = (1 << ADDR_W) - 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W     = $clog2(ACK_TO) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shadow [STAT_ADDR];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [TMR_W-1:0]  timer;
    logic              ovf;
    logic              to_err;
    logic [DATA_W-1:0] rd_data_p1;
    logic              rd_vld_p1;
    logic [ADDR_W-1:0] wa_addr_p1;
    logic [DATA_W-1:0] wa_data_p1;

    logic              is_stat;
    logic              full;
    logic              empty;
    logic              wr_data;
    logic              push;
    logic              ovf_set;
    logic              stat_wr;
    logic              rd_req;
    logic              tmo;
    logic              pop;
    logic [DATA_W-1:0] status;

    // Full/empty come from the registered count, so a same-cycle pop never admits a push.
    always_comb begin
        is_stat = (bus.xa_addr == ADDR_W'(STAT_ADDR));
        full    = (count == CNT_W'(FIFO_DEPTH));
        empty   = (count == '0);
        wr_data = bus.xa_wr_s && !is_stat;
        push    = wr_data && !full;
        ovf_set = wr_data && full;
        stat_wr = bus.xa_wr_s && is_stat;
        rd_req  = bus.xa_rd_s && !bus.xa_wr_s;
        tmo     = (state == S_WAIT) && !bus.wa_ack && (timer == TMR_W'(ACK_TO - 1));
        pop     = (state == S_WAIT) && (bus.wa_ack || tmo);
        status  = DATA_W'({to_err, ovf, full, empty});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (pop) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.xa_addr;
            fifo_data[wr_ptr] <= bus.xa_data_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            timer  <= '0;
            ovf    <= 1'b0;
            to_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (state == S_ISSUE)             timer <= '0;
            else if (state == S_WAIT && !pop) timer <= timer + TMR_W'(1);
            // A new event in the same cycle as its W1C clear keeps the bit set.
            ovf    <= ovf_set | (ovf & ~(stat_wr & bus.xa_data_wr[2]));
            to_err <= tmo | (to_err & ~(stat_wr & bus.xa_data_wr[3]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAT_ADDR; i++) shadow[i] <= '0;
        end else if (push) begin
            shadow[bus.xa_addr] <= bus.xa_data_wr;
        end
    end

    // Stage p1: registered read return and latched downstream head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_p1 <= '0;
            rd_vld_p1  <= 1'b0;
            wa_addr_p1 <= '0;
            wa_data_p1 <= '0;
        end else begin
            rd_vld_p1 <= rd_req;
            if (rd_req) rd_data_p1 <= is_stat ? status : shadow[bus.xa_addr];
            if (state == S_IDLE && !empty) begin
                wa_addr_p1 <= fifo_addr[rd_ptr];
                wa_data_p1 <= fifo_data[rd_ptr];
            end
        end
    end

    assign bus.xa_data_rd = rd_data_p1;
    assign bus.xa_rd_vld  = rd_vld_p1;
    assign bus.xa_full    = full;
    assign bus.wa_wr_s    = (state == S_ISSUE);
    assign bus.wa_addr    = wa_addr_p1;
    assign bus.wa_data_wr = wa_data_p1;
endmodule
